adc_result_avg: RTL and testbench

ADC_RESULT_AVG -- requirements
Module: adc_result_avg

---
 rtl/adc_result_avg.sv | 144 ++++++++++++++
 tb/tb_adc_result_avg.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_result_avg.sv
// rtl/adc_result_avg.sv - multi-slope ADC result scaler and block averager
// Serial shift-add scaling of each result, then 2^LOG2_AVG-sample averaging per run-up setting.
module adc_result_avg #(
  parameter logic [15:0] RUNUP_WEIGHT = 16'd4000,
  parameter int          LOG2_AVG     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_avg,
  output logic [14:0] out_setting,
  output logic        overrun,
  output logic        restart
);

  localparam logic [8:0] N_SAMP = 9'(1 << LOG2_AVG);

  typedef enum logic [1:0] {IDLE, MUL, ACC, HOLD} state_t;

  state_t             state_q;
  logic [47:0]        res_q;
  logic [4:0]         step_q;
  logic signed [31:0] mcand_q;
  logic [15:0]        mplier_q;
  logic signed [31:0] prod_q;
  logic signed [39:0] acc_q;
  logic [8:0]         cnt_q;
  logic [14:0]        bset_q;
  logic               out_valid_q;
  logic [31:0]        out_avg_q;
  logic [14:0]        out_set_q;
  logic               overrun_q;
  logic               restart_q;

  logic [15:0]        runup_cnt_d;
  logic [14:0]        set_d;
  logic signed [16:0] net_d;
  logic signed [31:0] rd_ext_d;
  logic signed [31:0] sample_d;
  logic signed [39:0] sample_ext_d;
  logic               match_d;
  logic [8:0]         cnt_next_d;
  logic [31:0]        avg_d;

  // Bit 47 is a zero guard, so the run-up count is read as a 16-bit unsigned field.
  assign runup_cnt_d  = res_q[47:32];
  assign set_d        = res_q[30:16];
  assign net_d        = $signed({runup_cnt_d, 1'b0}) - $signed({2'b00, set_d}) - 17'sd1;
  assign rd_ext_d     = $signed({16'd0, res_q[15:0]});
  assign sample_d     = res_q[31] ? (prod_q + rd_ext_d) : (prod_q - rd_ext_d);
  assign sample_ext_d = {{8{sample_d[31]}}, sample_d};
  assign match_d      = (cnt_q == 9'd0) || (set_d == bset_q);
  assign cnt_next_d   = match_d ? (cnt_q + 9'd1) : 9'd1;
  assign avg_d        = 32'(acc_q >>> LOG2_AVG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      res_q       <= '0;
      step_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      bset_q      <= '0;
      out_valid_q <= 1'b0;
      out_avg_q   <= '0;
      out_set_q   <= '0;
      overrun_q   <= 1'b0;
      restart_q   <= 1'b0;
    end else begin
      restart_q <= 1'b0;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            res_q   <= in_result;
            step_q  <= '0;
            state_q <= MUL;
          end
        end
        MUL: begin
          // Step 0 loads the operands; steps 1..16 each retire one multiplier bit.
          if (step_q == 5'd0) begin
            mcand_q  <= {{15{net_d[16]}}, net_d};
            mplier_q <= RUNUP_WEIGHT;
            prod_q   <= '0;
            step_q   <= 5'd1;
          end else begin
            if (mplier_q[0]) prod_q <= prod_q + mcand_q;
            mcand_q  <= mcand_q <<< 1;
            mplier_q <= mplier_q >> 1;
            if (step_q == 5'd16) begin
              step_q  <= '0;
              state_q <= ACC;
            end else begin
              step_q <= step_q + 5'd1;
            end
          end
        end
        ACC: begin
          if (cnt_q == N_SAMP) begin
            if (!out_valid_q || out_ready) begin
              out_avg_q   <= avg_d;
              out_set_q   <= bset_q;
              out_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= HOLD;
          end else begin
            if (match_d) begin
              acc_q <= acc_q + sample_ext_d;
            end else begin
              acc_q     <= sample_ext_d;
              restart_q <= 1'b1;
            end
            cnt_q   <= cnt_next_d;
            bset_q  <= set_d;
            // A full batch lingers one more cycle in ACC to form the average.
            state_q <= (cnt_next_d == N_SAMP) ? ACC : IDLE;
          end
        end
        HOLD:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign out_avg     = out_avg_q;
  assign out_setting = out_set_q;
  assign overrun     = overrun_q;
  assign restart     = restart_q;

endmodule

// File: tb/tb_adc_result_avg.sv
// tb/tb_adc_result_avg.sv - bench for adc_result_avg at LOG2_AVG 0, 1 and 2
// Directed scenarios plus random traffic against a transaction-level model.
module tb_adc_result_avg;

  localparam int W = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [47:0] in_result [3];
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [31:0] out_avg [3];
  logic [14:0] out_setting [3];
  logic [2:0]  overrun;
  logic [2:0]  restart;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    adc_result_avg #(.RUNUP_WEIGHT(16'(W)), .LOG2_AVG(g)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_result  (in_result[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_avg    (out_avg[g]),
      .out_setting(out_setting[g]),
      .overrun    (overrun[g]),
      .restart    (restart[g])
    );
  end

  int n_vec  = 0;
  int n_miss = 0;

  // Model state: values expected after the next clock edge.
  longint m_cyc;
  bit     m_ready [3];
  bit     m_valid [3];
  bit     m_ovr   [3];
  bit     m_rs    [3];
  longint m_avg   [3];
  longint m_set   [3];
  longint b_sum   [3];
  int     b_cnt   [3];
  longint b_set   [3];
  longint fin_edge [3];
  longint fin_avg  [3];
  longint fin_set  [3];
  longint rs_edge  [3];
  longint busy_until [3];
  int     rs_seen [3];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [47:0] mk(input int cnt, input bit sg, input int set, input int rd);
    return {1'b0, 15'(cnt), sg, 15'(set), 16'(rd)};
  endfunction

  function automatic longint model_sample(input logic [47:0] r);
    longint net;
    net = 2 * longint'(r[46:32]) - (longint'(r[30:16]) + 1);
    return net * W + (r[31] ? longint'(r[15:0]) : -longint'(r[15:0]));
  endfunction

  function automatic longint floor_avg(input longint s, input int l);
    longint n;
    n = longint'(1) << l;
    return (s >= 0) ? (s / n) : -((-s + n - 1) / n);
  endfunction

  task automatic model_reset(input int k);
    m_ready[k] = 1; m_valid[k] = 0; m_ovr[k] = 0; m_rs[k] = 0;
    m_avg[k] = 0; m_set[k] = 0; b_sum[k] = 0; b_cnt[k] = 0; b_set[k] = 0;
    fin_edge[k] = -1; fin_avg[k] = 0; fin_set[k] = 0; rs_edge[k] = -1; busy_until[k] = 0;
  endtask

  task automatic checker_loop();
    longint s;
    bit nv, nr;
    m_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      model_reset(k);
      rs_seen[k] = 0;
    end
    forever begin
      @(negedge clk);
      if (rst) for (int k = 0; k < 3; k++) model_reset(k);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("in_ready[%0d]", k), in_ready[k], m_ready[k]);
        chk($sformatf("out_valid[%0d]", k), out_valid[k], m_valid[k]);
        chk($sformatf("overrun[%0d]", k), overrun[k], m_ovr[k]);
        chk($sformatf("restart[%0d]", k), restart[k], m_rs[k]);
        if (m_valid[k]) begin
          chk($sformatf("out_avg[%0d]", k), $signed(out_avg[k]), m_avg[k]);
          chk($sformatf("out_setting[%0d]", k), out_setting[k], m_set[k]);
        end
        rs_seen[k] += int'(restart[k]);
      end
      if (!rst) begin
        m_cyc++;
        for (int k = 0; k < 3; k++) begin
          nv = m_valid[k] && !out_ready[k];
          if (fin_edge[k] == m_cyc) begin
            if (!m_valid[k] || out_ready[k]) begin
              nv = 1; m_avg[k] = fin_avg[k]; m_set[k] = fin_set[k];
            end else begin
              m_ovr[k] = 1;
            end
            fin_edge[k] = -1;
          end
          nr = (m_cyc >= busy_until[k]);
          m_rs[k] = (rs_edge[k] == m_cyc);
          if (in_valid[k] && m_ready[k]) begin
            s = model_sample(in_result[k]);
            if (b_cnt[k] == 0 || longint'(in_result[k][30:16]) == b_set[k]) begin
              b_sum[k] += s; b_cnt[k]++;
            end else begin
              b_sum[k] = s; b_cnt[k] = 1; rs_edge[k] = m_cyc + 18;
            end
            b_set[k] = longint'(in_result[k][30:16]);
            if (b_cnt[k] == (1 << k)) begin
              fin_edge[k] = m_cyc + 19;
              fin_avg[k] = floor_avg(b_sum[k], k);
              fin_set[k] = b_set[k];
              b_sum[k] = 0; b_cnt[k] = 0;
              busy_until[k] = m_cyc + 20;
            end else begin
              busy_until[k] = m_cyc + 18;
            end
            nr = 0;
          end
          m_valid[k] = nv;
          m_ready[k] = nr;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int k, input logic [47:0] r);
    int n;
    n = 0;
    in_result[k] = r;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && n < 200) begin
      tick();
      n++;
    end
    chk($sformatf("send_ready[%0d]", k), in_ready[k], 1);
    tick();
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    while (!out_valid[k] && n < 60) begin
      tick();
      n++;
    end
    chk($sformatf("wait_valid[%0d]", k), out_valid[k], 1);
  endtask

  task automatic consume(input int k);
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
  endtask

  initial begin
    logic [2:0] pre;
    int p0, r;
    in_valid = '0;
    out_ready = '0;
    for (int k = 0; k < 3; k++) in_result[k] = '0;
    fork
      checker_loop();
    join_none

    chk("model_s1", model_sample(mk(1100, 1, 1999, 500)), 800500);
    chk("model_floor", floor_avg(-3, 1), -2);
    chk("model_s2", floor_avg(-1000, 2), -250);

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_ready", in_ready[2], 1);
    chk("reset_avg", out_avg[2], 0);
    chk("reset_setting", out_setting[2], 0);

    // Single-sample average and its latency.
    send(0, mk(1100, 1, 1999, 500));
    repeat (18) tick();
    chk("s1_valid_at_18", out_valid[0], 0);
    tick();
    chk("s1_valid_at_19", out_valid[0], 1);
    chk("s1_avg", $signed(out_avg[0]), 800500);
    consume(0);

    send(1, mk(1000, 0, 1999, 1));
    send(1, mk(1000, 0, 1999, 2));
    wait_valid(1);
    chk("s6_avg_floor", $signed(out_avg[1]), -2);
    consume(1);

    for (int i = 1; i <= 4; i++) send(2, mk(1000, 0, 1999, 100 * i));
    wait_valid(2);
    chk("s2_avg", $signed(out_avg[2]), -250);
    chk("s2_setting", out_setting[2], 1999);
    consume(2);

    p0 = rs_seen[2];
    send(2, mk(1000, 0, 1999, 0));
    send(2, mk(1000, 0, 1999, 0));
    for (int i = 0; i < 3; i++) send(2, mk(1000, 0, 999, 0));
    repeat (20) tick();
    chk("s3_not_yet_valid", out_valid[2], 0);
    chk("s3_restart_pulses", rs_seen[2] - p0, 1);
    send(2, mk(1000, 0, 999, 0));
    wait_valid(2);
    chk("s3_setting", out_setting[2], 999);
    chk("s3_avg", $signed(out_avg[2]), 4000000);
    consume(2);

    for (int i = 0; i < 4; i++) send(2, mk(1000, 1, 1999, 40));
    wait_valid(2);
    for (int i = 0; i < 4; i++) send(2, mk(1000, 1, 1999, 80));
    repeat (25) tick();
    chk("s4_overrun", overrun[2], 1);
    chk("s4_still_valid", out_valid[2], 1);
    chk("s4_retained_avg", $signed(out_avg[2]), 40);
    out_ready[2] = 1'b1;
    tick();
    out_ready[2] = 1'b0;
    chk("s4_cleared", out_valid[2], 0);
    chk("s4_overrun_sticky", overrun[2], 1);

    // Reset in the middle of the multiply, with a partial batch pending.
    send(2, mk(1000, 0, 1999, 1000));
    send(2, mk(1000, 0, 1999, 1000));
    send(2, mk(1000, 0, 1999, 1000));
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("s5_async_ready", in_ready[2], 1);
    tick();
    rst = 1'b0;
    tick();
    chk("s5_ready", in_ready[2], 1);
    chk("s5_valid", out_valid[2], 0);
    chk("s5_overrun", overrun[2], 0);
    for (int i = 1; i <= 4; i++) send(2, mk(1000, 1, 1999, 4 * i));
    wait_valid(2);
    chk("s5_avg", $signed(out_avg[2]), 10);
    consume(2);

    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 3; k++) pre[k] = in_valid[k] && in_ready[k];
      tick();
      for (int k = 0; k < 3; k++) begin
        if (pre[k]) in_valid[k] = 1'b0;
        if (!in_valid[k] && $urandom_range(0, 2) == 0) begin
          r = int'($urandom_range(0, 15));
          in_result[k] = mk(int'($urandom_range(0, 32767)), 1'($urandom_range(0, 1)),
                            (r < 10) ? 1999 : (r < 14) ? 999 : (r == 14) ? 32767
                                     : int'($urandom_range(0, 32767)),
                            int'($urandom_range(0, 65535)));
          in_valid[k] = 1'b1;
        end
        out_ready[k] = (c < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      end
    end
    in_valid = '0;
    out_ready = '1;
    repeat (60) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
